// File: rtl/nim_pkg.sv
// Shared types and helpers for the Nim board renderer.
// Holds board geometry, the column and colour types, the render FSM states
// and the stone-count to column-mask mapping.
package nim_pkg;

    localparam int NUM_PILES  = 4;
    localparam int MAX_STONES = 8;
    localparam int NUM_COLS   = 8;

    typedef logic [7:0] col_t;
    typedef logic [2:0] rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        RENDER,
        SWAP
    } render_state_t;

    // Colour used for the selected pile while the blink phase is on.
    localparam rgb_t COLOR_SELECT = 3'b010;

    // Stones stack from the bottom row (LSB); counts of 8 or more fill the column.
    function automatic col_t stone_mask(input logic [3:0] count);
        if (count >= 4'(MAX_STONES)) begin
            return 8'hFF;
        end
        return (8'd1 << count[2:0]) - 8'd1;
    endfunction

endpackage

// File: rtl/nim_column_gen.sv
// Combinational column generator: turns a stone count and an {r,g,b}
// colour into one column for each of the three colour planes.
module nim_column_gen
    import nim_pkg::*;
(
    input  logic [3:0] count,
    input  logic [2:0] colour,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    col_t mask;

    // Build the stone mask and gate it into each plane by its colour bit.
    always_comb begin
        mask  = stone_mask(count);
        red   = colour[2] ? mask : 8'h00;
        green = colour[1] ? mask : 8'h00;
        blue  = colour[0] ? mask : 8'h00;
    end

endmodule

// File: rtl/nim_board_renderer.sv
// Nim board renderer: snapshots the game state, draws it one column per
// cycle into a back buffer, then swaps it into the registered front buffer.
// Also owns the blink timer that flashes the selected pile.
// Optional feature macro: NIM_WIN_FLASH_EN (whole-board flash on game over).
module nim_board_renderer
    import nim_pkg::*;
#(
    parameter int         BLINK_DIV     = 25_000_000,
    parameter logic [2:0] PILE_COLOR_P0 = 3'b100,
    parameter logic [2:0] PILE_COLOR_P1 = 3'b001
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [0:3][3:0] pile_count,
    input  logic            player,
    input  logic            sel_valid,
    input  logic [1:0]      sel_pile,
    input  logic            game_over,
    input  logic            update_req,
    output logic            busy,
    output logic            frame_done,
    output logic [0:7][7:0] image_red,
    output logic [0:7][7:0] image_green,
    output logic [0:7][7:0] image_blue
);

    localparam int BLINK_W = $clog2(BLINK_DIV);

    render_state_t state;
    render_state_t next_state;

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               blink_wrap;
    logic               new_request;
    logic               trigger;
    logic               pending;

    logic [0:3][3:0]    snap_count;
    logic               snap_player;
    logic               snap_sel_valid;
    logic [1:0]         snap_sel_pile;
    logic               snap_phase;
`ifdef NIM_WIN_FLASH_EN
    logic               snap_game_over;
`else
    logic               unused_game_over;
`endif

    logic [2:0]         col;
    logic [3:0]         render_count;
    logic [2:0]         render_colour;
    logic [7:0]         gen_red;
    logic [7:0]         gen_green;
    logic [7:0]         gen_blue;

    logic [0:7][7:0]    back_red;
    logic [0:7][7:0]    back_green;
    logic [0:7][7:0]    back_blue;

    assign blink_wrap  = (blink_cnt == BLINK_W'(BLINK_DIV - 1));
    assign new_request = update_req | blink_wrap;
    assign trigger     = new_request | pending;
    assign busy        = (state != IDLE);

`ifndef NIM_WIN_FLASH_EN
    // game_over only matters for the win flash; keep it visibly consumed.
    assign unused_game_over = game_over;
`endif

    // Blink timer: free-running half-period counter that flips the phase on wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Render FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Render FSM next-state: idle until triggered, eight column cycles, one swap.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trigger) next_state = RENDER;
            RENDER:  if (col == 3'd7) next_state = SWAP;
            SWAP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Snapshot, column counter, pending flag and the post-swap frame_done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_count     <= '0;
            snap_player    <= 1'b0;
            snap_sel_valid <= 1'b0;
            snap_sel_pile  <= 2'd0;
            snap_phase     <= 1'b0;
`ifdef NIM_WIN_FLASH_EN
            snap_game_over <= 1'b0;
`endif
            col            <= 3'd0;
            pending        <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= (state == SWAP);
            case (state)
                IDLE: begin
                    if (trigger) begin
                        snap_count     <= pile_count;
                        snap_player    <= player;
                        snap_sel_valid <= sel_valid;
                        snap_sel_pile  <= sel_pile;
                        // Capture the phase the timer is moving to on this edge.
                        snap_phase     <= blink_phase ^ blink_wrap;
`ifdef NIM_WIN_FLASH_EN
                        snap_game_over <= game_over;
`endif
                        col            <= 3'd0;
                        pending        <= 1'b0;
                    end
                end
                RENDER: begin
                    col <= col + 3'd1;
                    if (new_request) pending <= 1'b1;
                end
                SWAP: begin
                    if (new_request) pending <= 1'b1;
                end
                default: begin
                    col <= 3'd0;
                end
            endcase
        end
    end

    // Pick the stone count and colour for the column being drawn this cycle.
    always_comb begin
        render_count  = snap_count[col[2:1]];
        render_colour = snap_player ? PILE_COLOR_P1 : PILE_COLOR_P0;
        if (snap_sel_valid && (snap_sel_pile == col[2:1]) && snap_phase) begin
            render_colour = COLOR_SELECT;
        end
`ifdef NIM_WIN_FLASH_EN
        if (snap_game_over) begin
            render_count  = snap_phase ? 4'd8 : 4'd0;
            render_colour = snap_player ? PILE_COLOR_P1 : PILE_COLOR_P0;
        end
`endif
    end

    nim_column_gen u_column_gen (
        .count  (render_count),
        .colour (render_colour),
        .red    (gen_red),
        .green  (gen_green),
        .blue   (gen_blue)
    );

    // Back buffer: one column written per RENDER cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            back_red   <= '0;
            back_green <= '0;
            back_blue  <= '0;
        end else if (state == RENDER) begin
            back_red[col]   <= gen_red;
            back_green[col] <= gen_green;
            back_blue[col]  <= gen_blue;
        end
    end

    // Front buffer: whole frame copied in the single SWAP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            image_red   <= '0;
            image_green <= '0;
            image_blue  <= '0;
        end else if (state == SWAP) begin
            image_red   <= back_red;
            image_green <= back_green;
            image_blue  <= back_blue;
        end
    end

endmodule

// File: tb/tb_nim_board_renderer.sv
// Self-checking bench for nim_board_renderer: constant vector table,
// randomized renders against a behavioural model, and hand-written
// sequences for latency, snapshot, pending, reset and blink behaviour.
module tb_nim_board_renderer;

`ifdef NIM_WIN_FLASH_EN
    localparam bit WIN_FLASH_BUILD = 1'b1;
`else
    localparam bit WIN_FLASH_BUILD = 1'b0;
`endif

    typedef struct {
        logic [0:7][7:0] r;
        logic [0:7][7:0] g;
        logic [0:7][7:0] b;
    } img_t;

    typedef struct {
        logic [0:3][3:0] counts;
        logic            player;
        logic            sel_valid;
        logic [1:0]      sel_pile;
        logic [0:7][7:0] exp_r;
        logic [0:7][7:0] exp_g;
        logic [0:7][7:0] exp_b;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [0:3][3:0] pile_count;
    logic            player;
    logic            sel_valid;
    logic [1:0]      sel_pile;
    logic            game_over;
    logic            update_req;
    logic            update_req_b;

    logic            busy;
    logic            frame_done;
    logic [0:7][7:0] image_red;
    logic [0:7][7:0] image_green;
    logic [0:7][7:0] image_blue;

    logic            busy_b;
    logic            frame_done_b;
    logic [0:7][7:0] image_red_b;
    logic [0:7][7:0] image_green_b;
    logic [0:7][7:0] image_blue_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nim_board_renderer #(.BLINK_DIV(5000)) dut (
        .clk         (clk),
        .reset       (reset),
        .pile_count  (pile_count),
        .player      (player),
        .sel_valid   (sel_valid),
        .sel_pile    (sel_pile),
        .game_over   (game_over),
        .update_req  (update_req),
        .busy        (busy),
        .frame_done  (frame_done),
        .image_red   (image_red),
        .image_green (image_green),
        .image_blue  (image_blue)
    );

    nim_board_renderer #(.BLINK_DIV(16)) dut_b (
        .clk         (clk),
        .reset       (reset),
        .pile_count  (pile_count),
        .player      (player),
        .sel_valid   (sel_valid),
        .sel_pile    (sel_pile),
        .game_over   (game_over),
        .update_req  (update_req_b),
        .busy        (busy_b),
        .frame_done  (frame_done_b),
        .image_red   (image_red_b),
        .image_green (image_green_b),
        .image_blue  (image_blue_b)
    );

    // Reference picture straight from the board rules.
    function automatic img_t model(input logic [0:3][3:0] c, input logic p, input logic sv,
                                   input logic [1:0] sp, input logic ph, input logic go);
        img_t       m;
        int         h;
        int         mask;
        logic [2:0] colour;
        for (int k = 0; k < 4; k++) begin
            h      = (c[k] > 4'd8) ? 8 : int'(c[k]);
            mask   = (1 << h) - 1;
            colour = p ? 3'b001 : 3'b100;
            if (sv && (int'(sp) == k) && ph) colour = 3'b010;
            if (go && WIN_FLASH_BUILD) begin
                mask   = ph ? 255 : 0;
                colour = p ? 3'b001 : 3'b100;
            end
            m.r[2*k]   = colour[2] ? 8'(mask) : 8'h00;
            m.r[2*k+1] = colour[2] ? 8'(mask) : 8'h00;
            m.g[2*k]   = colour[1] ? 8'(mask) : 8'h00;
            m.g[2*k+1] = colour[1] ? 8'(mask) : 8'h00;
            m.b[2*k]   = colour[0] ? 8'(mask) : 8'h00;
            m.b[2*k+1] = colour[0] ? 8'(mask) : 8'h00;
        end
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one game state, pulse update_req, and wait (bounded) for frame_done.
    task automatic applyStimulus(input logic [0:3][3:0] c, input logic p, input logic sv,
                                 input logic [1:0] sp, output int latency);
        @(negedge clk);
        pile_count = c;
        player     = p;
        sel_valid  = sv;
        sel_pile   = sp;
        update_req = 1'b1;
        latency    = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            update_req = 1'b0;
            if (frame_done) begin
                latency = i;
                break;
            end
        end
    endtask

    // Wait (bounded) for the next frame_done of the fast-blink instance.
    task automatic waitFrameB(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!frame_done_b && cycles < 40);
    endtask

    // Watch the fast-blink instance flash pile 1 and check alternation and spacing.
    task automatic runBlink(input logic go);
        img_t m0;
        img_t m1;
        img_t exp;
        logic ph;
        int   cyc;
        @(negedge clk);
        pile_count = {4'd1, 4'd3, 4'd5, 4'd8};
        player     = 1'b0;
        sel_valid  = 1'b1;
        sel_pile   = 2'd1;
        game_over  = go;
        repeat (20) @(negedge clk);
        m0 = model(pile_count, 1'b0, 1'b1, 2'd1, 1'b0, go);
        m1 = model(pile_count, 1'b0, 1'b1, 2'd1, 1'b1, go);
        waitFrameB(cyc);
        checkOutput("blink_first_frame", 64'(frame_done_b), 64'd1);
        ph  = (image_red_b == m1.r) && (image_green_b == m1.g) && (image_blue_b == m1.b);
        exp = ph ? m1 : m0;
        checkOutput("blink_sync_red", image_red_b, exp.r);
        checkOutput("blink_sync_green", image_green_b, exp.g);
        for (int k = 0; k < 6; k++) begin
            waitFrameB(cyc);
            checkOutput("blink_interval", 64'(cyc), 64'd16);
            ph  = ~ph;
            exp = ph ? m1 : m0;
            checkOutput("blink_red", image_red_b, exp.r);
            checkOutput("blink_green", image_green_b, exp.g);
            checkOutput("blink_blue", image_blue_b, exp.b);
        end
    endtask

    initial begin
        vec_t            vecs[5];
        img_t            m;
        int              latency;
        int              fd_count;
        logic [0:3][3:0] c;
        logic [0:3][3:0] snap_a;
        logic [0:7][7:0] prev_red;

        vecs[0] = '{{4'd1, 4'd3, 4'd5, 4'd8}, 1'b0, 1'b0, 2'd0,
                    {8'h01, 8'h01, 8'h07, 8'h07, 8'h1F, 8'h1F, 8'hFF, 8'hFF}, 64'h0, 64'h0};
        vecs[1] = '{{4'd1, 4'd3, 4'd12, 4'd0}, 1'b1, 1'b0, 2'd0,
                    64'h0, 64'h0, {8'h01, 8'h01, 8'h07, 8'h07, 8'hFF, 8'hFF, 8'h00, 8'h00}};
        vecs[2] = '{{4'd0, 4'd0, 4'd0, 4'd0}, 1'b1, 1'b0, 2'd0, 64'h0, 64'h0, 64'h0};
        vecs[3] = '{{4'd2, 4'd4, 4'd6, 4'd7}, 1'b1, 1'b1, 2'd2,
                    64'h0, 64'h0, {8'h03, 8'h03, 8'h0F, 8'h0F, 8'h3F, 8'h3F, 8'h7F, 8'h7F}};
        vecs[4] = '{{4'd15, 4'd9, 4'd8, 4'd0}, 1'b0, 1'b0, 2'd0,
                    {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00}, 64'h0, 64'h0};

        reset        = 1'b1;
        pile_count   = '0;
        player       = 1'b0;
        sel_valid    = 1'b0;
        sel_pile     = 2'd0;
        game_over    = 1'b0;
        update_req   = 1'b0;
        update_req_b = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_red", image_red, 64'h0);
        checkOutput("reset_green", image_green, 64'h0);
        checkOutput("reset_blue", image_blue, 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_frame_done", 64'(frame_done), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("blank_before_render", image_red | image_green | image_blue, 64'h0);

        $display("[TB] vector table");
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].counts, vecs[v].player, vecs[v].sel_valid, vecs[v].sel_pile, latency);
            checkOutput("table_latency", 64'(latency), 64'd10);
            checkOutput("table_red", image_red, vecs[v].exp_r);
            checkOutput("table_green", image_green, vecs[v].exp_g);
            checkOutput("table_blue", image_blue, vecs[v].exp_b);
            @(negedge clk);
            checkOutput("table_frame_done_width", 64'(frame_done), 64'd0);
        end

        $display("[TB] cycle timing");
        prev_red = image_red;
        @(negedge clk);
        pile_count = {4'd4, 4'd4, 4'd4, 4'd4};
        player     = 1'b0;
        sel_valid  = 1'b0;
        update_req = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            update_req = 1'b0;
            if (i == 1) checkOutput("timing_busy_c1", 64'(busy), 64'd1);
            if (i == 9) begin
                checkOutput("timing_busy_c9", 64'(busy), 64'd1);
                checkOutput("timing_old_image_c9", image_red, prev_red);
                checkOutput("timing_no_done_c9", 64'(frame_done), 64'd0);
            end
            if (i == 10) begin
                checkOutput("timing_busy_c10", 64'(busy), 64'd0);
                checkOutput("timing_new_image_c10", image_red, {8{8'h0F}});
                checkOutput("timing_done_c10", 64'(frame_done), 64'd1);
            end
        end

        $display("[TB] randomized renders");
        for (int n = 0; n < 20; n++) begin
            logic       rp;
            logic       rsv;
            logic [1:0] rsp;
            for (int k = 0; k < 4; k++) c[k] = 4'($urandom_range(0, 15));
            rp  = 1'($urandom_range(0, 1));
            rsv = 1'($urandom_range(0, 1));
            rsp = 2'($urandom_range(0, 3));
            m   = model(c, rp, rsv, rsp, 1'b0, 1'b0);
            applyStimulus(c, rp, rsv, rsp, latency);
            checkOutput("rand_latency", 64'(latency), 64'd10);
            checkOutput("rand_red", image_red, m.r);
            checkOutput("rand_green", image_green, m.g);
            checkOutput("rand_blue", image_blue, m.b);
        end

        $display("[TB] snapshot isolation");
        snap_a = {4'd2, 4'd2, 4'd2, 4'd2};
        @(negedge clk);
        pile_count = snap_a;
        player     = 1'b0;
        sel_valid  = 1'b0;
        update_req = 1'b1;
        latency    = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            update_req = 1'b0;
            if (i == 3) begin
                pile_count = {4'd7, 4'd7, 4'd7, 4'd7};
                player     = 1'b1;
            end
            if (frame_done) begin
                latency = i;
                break;
            end
        end
        m = model(snap_a, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        checkOutput("snapshot_latency", 64'(latency), 64'd10);
        checkOutput("snapshot_red", image_red, m.r);
        checkOutput("snapshot_blue", image_blue, m.b);

        $display("[TB] triggers while busy");
        @(negedge clk);
        pile_count = {4'd1, 4'd2, 4'd3, 4'd4};
        player     = 1'b0;
        update_req = 1'b1;
        fd_count   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            update_req = (i == 2) || (i == 4) || (i == 6);
            if (i == 2) begin
                pile_count = {4'd8, 4'd0, 4'd8, 4'd0};
                player     = 1'b1;
            end
            if (frame_done) fd_count++;
            if (i == 10) begin
                m = model({4'd1, 4'd2, 4'd3, 4'd4}, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
                checkOutput("pending_first_done", 64'(frame_done), 64'd1);
                checkOutput("pending_first_red", image_red, m.r);
            end
            if (i == 20) begin
                m = model({4'd8, 4'd0, 4'd8, 4'd0}, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
                checkOutput("pending_second_done", 64'(frame_done), 64'd1);
                checkOutput("pending_second_blue", image_blue, m.b);
                checkOutput("pending_second_red", image_red, m.r);
            end
        end
        checkOutput("pending_done_count", 64'(fd_count), 64'd2);

        $display("[TB] reset mid-render");
        @(negedge clk);
        pile_count = {4'd5, 4'd5, 4'd5, 4'd5};
        update_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            update_req = 1'b0;
        end
        checkOutput("midreset_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("midreset_red", image_red, 64'h0);
        checkOutput("midreset_green", image_green, 64'h0);
        checkOutput("midreset_blue", image_blue, 64'h0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        fd_count = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame_done) fd_count++;
        end
        checkOutput("midreset_no_done", 64'(fd_count), 64'd0);
        checkOutput("midreset_still_blank", image_red | image_green | image_blue, 64'h0);

        $display("[TB] blink with selection");
        runBlink(1'b0);
        $display("[TB] blink with game over");
        runBlink(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
